// File: rtl/score_engine.sv
// Mastermind-style scorer: latches a code and a guess, counts exact then partial
// matches over a fixed 22-cycle schedule, and drives registered feedback pegs.
module score_engine #(
   parameter int unsigned COLOR_W = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [COLOR_W-1:0] code0,
   input  logic [COLOR_W-1:0] code1,
   input  logic [COLOR_W-1:0] code2,
   input  logic [COLOR_W-1:0] code3,
   input  logic [COLOR_W-1:0] guess0,
   input  logic [COLOR_W-1:0] guess1,
   input  logic [COLOR_W-1:0] guess2,
   input  logic [COLOR_W-1:0] guess3,
   output logic               busy,
   output logic               done,
   output logic [2:0]         exact,
   output logic [2:0]         partial,
   output logic [1:0]         peg0,
   output logic [1:0]         peg1,
   output logic [1:0]         peg2,
   output logic [1:0]         peg3,
   output logic               win
);

   typedef enum logic [2:0] {IDLE, LATCH, EXACT, PARTIAL, DONE} state_t;

   state_t             state, state_nx;
   logic [3:0]         idx;
   logic [1:0]         ii, jj;
   logic [COLOR_W-1:0] code_q  [4];
   logic [COLOR_W-1:0] guess_q [4];
   logic [3:0]         used_code, used_guess, used_code_nx, used_guess_nx;
   logic [2:0]         exact_cnt, partial_cnt, exact_nx, partial_nx, filled_nx;
   logic [1:0]         peg_q  [4];
   logic [1:0]         peg_nx [4];

   // In EXACT only idx[1:0] is used; in PARTIAL idx walks (i,j) with j fastest.
   assign ii = idx[3:2];
   assign jj = idx[1:0];

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx      = state;
      exact_nx      = exact_cnt;
      partial_nx    = partial_cnt;
      used_code_nx  = used_code;
      used_guess_nx = used_guess;
      case (state)
         IDLE: if (start) state_nx = LATCH;
         LATCH: begin
            exact_nx      = 3'd0;
            partial_nx    = 3'd0;
            used_code_nx  = 4'd0;
            used_guess_nx = 4'd0;
            state_nx      = EXACT;
         end
         EXACT: begin
            if (guess_q[jj] == code_q[jj]) begin
               exact_nx          = exact_cnt + 3'd1;
               used_code_nx[jj]  = 1'b1;
               used_guess_nx[jj] = 1'b1;
            end
            if (jj == 2'd3) state_nx = PARTIAL;
         end
         PARTIAL: begin
            if (!used_guess[ii] && !used_code[jj] && guess_q[ii] == code_q[jj]) begin
               partial_nx        = partial_cnt + 3'd1;
               used_code_nx[jj]  = 1'b1;
               used_guess_nx[ii] = 1'b1;
            end
            if (idx == 4'd15) state_nx = DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Pegs fill from peg3 downward: exact pegs first, then partial, then blanks.
   always_comb begin
      filled_nx = exact_nx + partial_nx;
      for (int k = 0; k < 4; k++) begin
         if (3'(3 - k) < exact_nx)       peg_nx[k] = 2'd2;
         else if (3'(3 - k) < filled_nx) peg_nx[k] = 2'd1;
         else                            peg_nx[k] = 2'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx         <= 4'd0;
         used_code   <= 4'd0;
         used_guess  <= 4'd0;
         exact_cnt   <= 3'd0;
         partial_cnt <= 3'd0;
         busy        <= 1'b0;
         done        <= 1'b0;
         exact       <= 3'd0;
         partial     <= 3'd0;
         win         <= 1'b0;
         for (int k = 0; k < 4; k++) begin
            code_q[k]  <= '0;
            guess_q[k] <= '0;
            peg_q[k]   <= 2'd0;
         end
      end else begin
         if (state == LATCH) begin
            code_q[0]  <= code0;
            code_q[1]  <= code1;
            code_q[2]  <= code2;
            code_q[3]  <= code3;
            guess_q[0] <= guess0;
            guess_q[1] <= guess1;
            guess_q[2] <= guess2;
            guess_q[3] <= guess3;
         end
         // Step index only while staying in a counting phase; restart on phase change.
         if ((state == EXACT || state == PARTIAL) && state_nx == state)
            idx <= idx + 4'd1;
         else
            idx <= 4'd0;
         used_code   <= used_code_nx;
         used_guess  <= used_guess_nx;
         exact_cnt   <= exact_nx;
         partial_cnt <= partial_nx;
         busy        <= (state_nx != IDLE);
         done        <= (state_nx == DONE);
         if (state_nx == DONE) begin
            exact   <= exact_nx;
            partial <= partial_nx;
            for (int k = 0; k < 4; k++) peg_q[k] <= peg_nx[k];
            if (exact_nx == 3'd4) win <= 1'b1;
         end
      end
   end

   assign peg0 = peg_q[0];
   assign peg1 = peg_q[1];
   assign peg2 = peg_q[2];
   assign peg3 = peg_q[3];

endmodule

// File: tb/tb_score_engine.sv
// Randomized and directed checks of score_engine against a colour-count scoring model.
module tb_score_engine;

   logic       clk = 1'b0;
   logic       rst, start;
   logic [2:0] code0, code1, code2, code3, guess0, guess1, guess2, guess3;
   logic       busy, done, win;
   logic [2:0] exact, partial;
   logic [1:0] peg0, peg1, peg2, peg3;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   bit win_exp = 1'b0;

   score_engine #(.COLOR_W(3)) dut (
      .clk(clk), .rst(rst), .start(start),
      .code0(code0), .code1(code1), .code2(code2), .code3(code3),
      .guess0(guess0), .guess1(guess1), .guess2(guess2), .guess3(guess3),
      .busy(busy), .done(done), .exact(exact), .partial(partial),
      .peg0(peg0), .peg1(peg1), .peg2(peg2), .peg3(peg3), .win(win)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (done) done_cnt++;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [11:0] pk(input int a0, input int a1, input int a2, input int a3);
      return {3'(a3), 3'(a2), 3'(a1), 3'(a0)};
   endfunction

   // Exact = positional matches; partial = shared colour counts minus exact.
   function automatic void model(input logic [11:0] c, input logic [11:0] g,
                                 output int ex, output int pa);
      int cc[8];
      int gc[8];
      logic [2:0] cv, gv;
      ex = 0;
      pa = 0;
      for (int k = 0; k < 8; k++) begin cc[k] = 0; gc[k] = 0; end
      for (int i = 0; i < 4; i++) begin
         cv = c[3*i +: 3];
         gv = g[3*i +: 3];
         if (cv == gv) ex++;
         cc[cv]++;
         gc[gv]++;
      end
      for (int k = 0; k < 8; k++) pa += (cc[k] < gc[k]) ? cc[k] : gc[k];
      pa -= ex;
   endfunction

   task automatic drive(input logic [11:0] c, input logic [11:0] g);
      {code3, code2, code1, code0}     = c;
      {guess3, guess2, guess1, guess0} = g;
   endtask

   // Runs one score from a negedge; optionally disturbs inputs mid-run or
   // holds start high through DONE and the following IDLE cycle.
   task automatic score(input logic [11:0] c, input logic [11:0] g,
                        input bit disturb, input bit hold_start);
      int n, ex, pa, dc0;
      int q[$];
      model(c, g, ex, pa);
      dc0 = done_cnt;
      drive(c, g);
      start = 1'b1;
      n = 0;
      while (n < 40) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (n == 1) begin
            chk("busy_after_start", busy, 1);
            start = 1'b0;
         end
         if (disturb && n == 3) begin
            drive($urandom, $urandom);
            start = 1'b1;
         end
         if (disturb && n == 4) start = 1'b0;
         if (done) break;
      end
      chk("latency", n, 22);
      chk("exact", exact, ex);
      chk("partial", partial, pa);
      for (int k = 0; k < ex; k++) q.push_back(2);
      for (int k = 0; k < pa; k++) q.push_back(1);
      while (q.size() < 4) q.push_back(0);
      chk("peg3", peg3, q[0]);
      chk("peg2", peg2, q[1]);
      chk("peg1", peg1, q[2]);
      chk("peg0", peg0, q[3]);
      if (ex == 4) win_exp = 1'b1;
      chk("win", win, int'(win_exp));
      if (hold_start) start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("idle_busy", busy, 0);
      chk("exact_hold", exact, ex);
      chk("done_pulses", done_cnt - dc0, 1);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_exact"}, exact, 0);
      chk({tag, "_partial"}, partial, 0);
      chk({tag, "_pegs"}, {peg3, peg2, peg1, peg0}, 0);
      chk({tag, "_win"}, win, 0);
   endtask

   initial begin
      int dc0;
      logic [11:0] rc, rg;
      rst = 1'b1;
      start = 1'b1;
      drive(pk(1, 2, 3, 4), pk(1, 2, 3, 4));
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_zero("reset");
      rst = 1'b0;
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("start_with_rst_dropped", busy, 0);

      score(pk(1, 2, 3, 4), pk(1, 2, 3, 4), 1'b0, 1'b0);
      score(pk(1, 2, 3, 4), pk(4, 3, 2, 1), 1'b0, 1'b0);
      score(pk(1, 1, 2, 2), pk(1, 2, 1, 5), 1'b0, 1'b0);
      score(pk(5, 5, 5, 5), pk(5, 0, 0, 0), 1'b0, 1'b0);
      score(pk(1, 2, 3, 4), pk(0, 0, 0, 0), 1'b0, 1'b0);
      score(pk(2, 6, 6, 3), pk(6, 2, 3, 6), 1'b1, 1'b0);

      // start held through DONE: ignored there, accepted on the first IDLE cycle.
      score(pk(7, 0, 7, 0), pk(0, 7, 7, 1), 1'b0, 1'b1);
      chk("start_in_done_ignored", busy, 0);
      score(pk(3, 3, 1, 0), pk(3, 1, 3, 3), 1'b0, 1'b0);

      // Abort mid-score with reset.
      dc0 = done_cnt;
      drive(pk(1, 2, 3, 4), pk(1, 2, 3, 4));
      start = 1'b1;
      for (int n = 1; n <= 10; n++) begin
         @(posedge clk);
         @(negedge clk);
         start = 1'b0;
      end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      win_exp = 1'b0;
      check_zero("abort");
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk("abort_no_done", done_cnt - dc0, 0);
      score(pk(4, 4, 2, 1), pk(4, 2, 4, 0), 1'b0, 1'b0);

      for (int t = 0; t < 24; t++) begin
         if (t % 2 == 0) begin
            rc = pk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            rg = pk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
         end else begin
            rc = 12'($urandom);
            rg = (t % 5 == 0) ? rc : 12'($urandom);
         end
         score(rc, rg, (t % 4 == 1), 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
